// File: rtl/painterengine_gpu_task_scheduler_pkg.sv
// rtl/painterengine_gpu_task_scheduler_pkg.sv - shared opcodes, status codes, FSM encoding and descriptor type
package painterengine_gpu_task_scheduler_pkg;

    localparam logic [1:0] GPU_OPCODE_MEMCPY       = 2'd0;
    localparam logic [1:0] GPU_OPCODE_COLORCONVERT = 2'd1;

    localparam logic [7:0] ENG_STATE_DONE             = 8'h08;
    localparam logic [7:0] ENG_STATE_LENGTH_ERROR     = 8'h09;
    localparam logic [7:0] ENG_STATE_DMA_READER_ERROR = 8'h0A;
    localparam logic [7:0] ENG_STATE_DMA_WRITER_ERROR = 8'h0B;

    localparam logic [7:0] SCHED_ILLEGAL_OPCODE = 8'hFE;
    localparam logic [7:0] SCHED_TIMEOUT        = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ISSUE    = 4'd1,
        ST_RUN      = 4'd2,
        ST_COMPLETE = 4'd3,
        ST_ERROR    = 4'd4
    } sched_state_e;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [31:0] source_address;
        logic [31:0] dest_address;
        logic [31:0] length;
    } gpu_desc_t;

    function automatic logic is_legal_opcode(input logic [1:0] op);
        return (op == GPU_OPCODE_MEMCPY) || (op == GPU_OPCODE_COLORCONVERT);
    endfunction

endpackage

// File: rtl/painterengine_gpu_task_scheduler_cmd_fifo.sv
// rtl/painterengine_gpu_task_scheduler_cmd_fifo.sv - synchronous descriptor FIFO with full/empty/level
module painterengine_gpu_cmd_fifo
    import painterengine_gpu_task_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_clear,
    input  logic       i_push,
    input  gpu_desc_t  i_data,
    input  logic       i_pop,
    output gpu_desc_t  o_data,
    output logic       o_full,
    output logic       o_empty,
    output logic [4:0] o_level
);
    localparam int AW = $clog2(DEPTH);

    gpu_desc_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_level = 5'(r_count);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge i_clock) begin
        if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/painterengine_gpu_task_scheduler.sv
// rtl/painterengine_gpu_task_scheduler.sv - descriptor queue, engine dispatch FSM and shared DMA/FIFO mux
module painterengine_gpu_task_scheduler
    import painterengine_gpu_task_scheduler_pkg::*;
#(
    parameter int          QUEUE_DEPTH    = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    parameter int          ISSUE_CYCLES   = 2
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_cmd_valid,
    output logic        o_wire_cmd_ready,
    input  logic [1:0]  i_wire_cmd_opcode,
    input  logic [31:0] i_wire_cmd_source_address,
    input  logic [31:0] i_wire_cmd_dest_address,
    input  logic [31:0] i_wire_cmd_length,
    input  logic        i_wire_clear,
    output logic [1:0]  o_wire_engine_resetn,
    output logic [31:0] o_wire_engine_source_address,
    output logic [31:0] o_wire_engine_dest_address,
    output logic [31:0] o_wire_engine_length,
    input  logic [63:0] i_wire_engine_state,
    input  logic [1:0]  i_wire_eng_dma_reader_resetn,
    input  logic [1:0]  i_wire_eng_dma_writer_resetn,
    input  logic [1:0]  i_wire_eng_fifo_resetn,
    input  logic [63:0] i_wire_eng_dma_reader_address,
    input  logic [63:0] i_wire_eng_dma_reader_length,
    input  logic [63:0] i_wire_eng_dma_writer_address,
    input  logic [63:0] i_wire_eng_dma_writer_length,
    output logic [1:0]  o_wire_eng_dma_reader_done,
    output logic [1:0]  o_wire_eng_dma_reader_error,
    output logic [1:0]  o_wire_eng_dma_writer_done,
    output logic [1:0]  o_wire_eng_dma_writer_error,
    output logic        o_wire_dma_reader_resetn,
    output logic        o_wire_dma_writer_resetn,
    output logic        o_wire_fifo_resetn,
    output logic [31:0] o_wire_dma_reader_address,
    output logic [31:0] o_wire_dma_reader_length,
    output logic [31:0] o_wire_dma_writer_address,
    output logic [31:0] o_wire_dma_writer_length,
    input  logic        i_wire_dma_reader_done,
    input  logic        i_wire_dma_reader_error,
    input  logic        i_wire_dma_writer_done,
    input  logic        i_wire_dma_writer_error,
    output logic [31:0] o_wire_state
);
    sched_state_e r_state;
    sched_state_e w_next_state;
    gpu_desc_t    w_push_desc;
    gpu_desc_t    w_head;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic [4:0]   w_fifo_level;
    logic         w_push;
    logic         w_pop;
    logic         r_sel;
    logic [31:0]  r_src;
    logic [31:0]  r_dst;
    logic [31:0]  r_len;
    logic [31:0]  r_issue_cnt;
    logic [31:0]  r_wdog;
    logic [15:0]  r_done_count;
    logic [7:0]   r_error_code;
    logic [7:0]   w_sel_state;
    logic         w_eng_done;
    logic         w_eng_err;
    logic         w_timeout;
    logic         w_issue_done;
    logic [3:0]   w_level4;
    logic         w_unused_state_bits;

    assign w_push_desc      = {i_wire_cmd_opcode, i_wire_cmd_source_address,
                               i_wire_cmd_dest_address, i_wire_cmd_length};
    assign o_wire_cmd_ready = !w_fifo_full && !i_wire_clear;
    assign w_push           = i_wire_cmd_valid && o_wire_cmd_ready;
    assign w_pop            = (r_state == ST_IDLE) && !w_fifo_empty && !i_wire_clear;

    assign w_sel_state  = r_sel ? i_wire_engine_state[39:32] : i_wire_engine_state[7:0];
    assign w_eng_done   = (w_sel_state == ENG_STATE_DONE);
    assign w_eng_err    = (w_sel_state == ENG_STATE_LENGTH_ERROR) ||
                          (w_sel_state == ENG_STATE_DMA_READER_ERROR) ||
                          (w_sel_state == ENG_STATE_DMA_WRITER_ERROR);
    assign w_timeout    = (r_wdog >= TIMEOUT_CYCLES - 32'd1);
    assign w_issue_done = (r_issue_cnt == 32'(ISSUE_CYCLES - 1));
    assign w_level4     = (w_fifo_level > 5'd15) ? 4'hF : w_fifo_level[3:0];
    assign w_unused_state_bits = ^{i_wire_engine_state[63:40], i_wire_engine_state[31:8]};

    painterengine_gpu_cmd_fifo #(.DEPTH(QUEUE_DEPTH)) u_cmd_fifo (
        .i_clock  (i_wire_clock),
        .i_resetn (i_wire_resetn),
        .i_clear  (i_wire_clear),
        .i_push   (w_push),
        .i_data   (w_push_desc),
        .i_pop    (w_pop),
        .o_data   (w_head),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty),
        .o_level  (w_fifo_level)
    );

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) r_state <= ST_IDLE;
        else                r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (i_wire_clear) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (!w_fifo_empty)
                                 w_next_state = is_legal_opcode(w_head.opcode) ? ST_ISSUE : ST_ERROR;
                ST_ISSUE:    if (w_issue_done) w_next_state = ST_RUN;
                ST_RUN:      if (w_eng_done)                  w_next_state = ST_COMPLETE;
                             else if (w_eng_err || w_timeout) w_next_state = ST_ERROR;
                ST_COMPLETE: w_next_state = ST_IDLE;
                ST_ERROR:    w_next_state = ST_ERROR;
                default:     w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            r_sel        <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_issue_cnt  <= '0;
            r_wdog       <= '0;
            r_done_count <= '0;
            r_error_code <= '0;
        end else begin
            if (w_pop) begin
                r_sel <= w_head.opcode[0];
                r_src <= w_head.source_address;
                r_dst <= w_head.dest_address;
                r_len <= w_head.length;
            end
            r_issue_cnt <= (r_state == ST_ISSUE) ? r_issue_cnt + 32'd1 : '0;
            // Watchdog restarts at zero on every RUN entry and saturates rather than wrapping.
            if (r_state != ST_RUN)     r_wdog <= '0;
            else if (r_wdog != '1)     r_wdog <= r_wdog + 32'd1;
            if (r_state == ST_COMPLETE && !i_wire_clear) r_done_count <= r_done_count + 16'd1;
            if (i_wire_clear)
                r_error_code <= '0;
            else if (w_pop && !is_legal_opcode(w_head.opcode))
                r_error_code <= SCHED_ILLEGAL_OPCODE;
            else if (r_state == ST_RUN && !w_eng_done && w_eng_err)
                r_error_code <= w_sel_state;
            else if (r_state == ST_RUN && !w_eng_done && w_timeout)
                r_error_code <= SCHED_TIMEOUT;
        end
    end

    always_comb begin
        o_wire_engine_resetn        = '0;
        o_wire_dma_reader_resetn    = 1'b0;
        o_wire_dma_writer_resetn    = 1'b0;
        o_wire_fifo_resetn          = 1'b0;
        o_wire_dma_reader_address   = '0;
        o_wire_dma_reader_length    = '0;
        o_wire_dma_writer_address   = '0;
        o_wire_dma_writer_length    = '0;
        o_wire_eng_dma_reader_done  = '0;
        o_wire_eng_dma_reader_error = '0;
        o_wire_eng_dma_writer_done  = '0;
        o_wire_eng_dma_writer_error = '0;
        if (r_state == ST_RUN) begin
            o_wire_engine_resetn[r_sel]        = 1'b1;
            o_wire_dma_reader_resetn           = i_wire_eng_dma_reader_resetn[r_sel];
            o_wire_dma_writer_resetn           = i_wire_eng_dma_writer_resetn[r_sel];
            o_wire_fifo_resetn                 = i_wire_eng_fifo_resetn[r_sel];
            o_wire_dma_reader_address          = r_sel ? i_wire_eng_dma_reader_address[63:32] : i_wire_eng_dma_reader_address[31:0];
            o_wire_dma_reader_length           = r_sel ? i_wire_eng_dma_reader_length[63:32]  : i_wire_eng_dma_reader_length[31:0];
            o_wire_dma_writer_address          = r_sel ? i_wire_eng_dma_writer_address[63:32] : i_wire_eng_dma_writer_address[31:0];
            o_wire_dma_writer_length           = r_sel ? i_wire_eng_dma_writer_length[63:32]  : i_wire_eng_dma_writer_length[31:0];
            o_wire_eng_dma_reader_done[r_sel]  = i_wire_dma_reader_done;
            o_wire_eng_dma_reader_error[r_sel] = i_wire_dma_reader_error;
            o_wire_eng_dma_writer_done[r_sel]  = i_wire_dma_writer_done;
            o_wire_eng_dma_writer_error[r_sel] = i_wire_dma_writer_error;
        end
    end

    assign o_wire_engine_source_address = r_src;
    assign o_wire_engine_dest_address   = r_dst;
    assign o_wire_engine_length         = r_len;
    assign o_wire_state = {r_done_count, r_error_code, w_level4, r_state};

endmodule

// File: tb/tb_painterengine_gpu_task_scheduler.sv
// tb/tb_painterengine_gpu_task_scheduler.sv - randomized scoreboard bench for the GPU task scheduler
module tb_painterengine_gpu_task_scheduler;
    import painterengine_gpu_task_scheduler_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;
    localparam int ISS   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, clear;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_src, cmd_dst, cmd_len;
    logic [1:0]  eng_rn;
    logic [31:0] eng_src, eng_dst, eng_len;
    logic [63:0] eng_state;
    logic [1:0]  e_rd_rn, e_wr_rn, e_ff_rn;
    logic [63:0] e_rd_addr, e_rd_len, e_wr_addr, e_wr_len;
    logic [1:0]  o_rd_done, o_rd_err, o_wr_done, o_wr_err;
    logic        d_rd_rn, d_wr_rn, d_ff_rn;
    logic [31:0] d_rd_addr, d_rd_len, d_wr_addr, d_wr_len;
    logic        rd_done, rd_err, wr_done, wr_err;
    logic [31:0] st;

    always #5 clk = ~clk;

    painterengine_gpu_task_scheduler #(
        .QUEUE_DEPTH(DEPTH), .TIMEOUT_CYCLES(32'(TMO)), .ISSUE_CYCLES(ISS)
    ) dut (
        .i_wire_clock(clk), .i_wire_resetn(rst_n),
        .i_wire_cmd_valid(cmd_valid), .o_wire_cmd_ready(cmd_ready),
        .i_wire_cmd_opcode(cmd_op), .i_wire_cmd_source_address(cmd_src),
        .i_wire_cmd_dest_address(cmd_dst), .i_wire_cmd_length(cmd_len),
        .i_wire_clear(clear), .o_wire_engine_resetn(eng_rn),
        .o_wire_engine_source_address(eng_src), .o_wire_engine_dest_address(eng_dst),
        .o_wire_engine_length(eng_len), .i_wire_engine_state(eng_state),
        .i_wire_eng_dma_reader_resetn(e_rd_rn), .i_wire_eng_dma_writer_resetn(e_wr_rn),
        .i_wire_eng_fifo_resetn(e_ff_rn),
        .i_wire_eng_dma_reader_address(e_rd_addr), .i_wire_eng_dma_reader_length(e_rd_len),
        .i_wire_eng_dma_writer_address(e_wr_addr), .i_wire_eng_dma_writer_length(e_wr_len),
        .o_wire_eng_dma_reader_done(o_rd_done), .o_wire_eng_dma_reader_error(o_rd_err),
        .o_wire_eng_dma_writer_done(o_wr_done), .o_wire_eng_dma_writer_error(o_wr_err),
        .o_wire_dma_reader_resetn(d_rd_rn), .o_wire_dma_writer_resetn(d_wr_rn),
        .o_wire_fifo_resetn(d_ff_rn),
        .o_wire_dma_reader_address(d_rd_addr), .o_wire_dma_reader_length(d_rd_len),
        .o_wire_dma_writer_address(d_wr_addr), .o_wire_dma_writer_length(d_wr_len),
        .i_wire_dma_reader_done(rd_done), .i_wire_dma_reader_error(rd_err),
        .i_wire_dma_writer_done(wr_done), .i_wire_dma_writer_error(wr_err),
        .o_wire_state(st)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] src, dst, len;
        bit          is_err;
        logic [7:0]  code;
        int          run_cycles;
    } exp_t;
    typedef struct {
        int         delay;
        logic [7:0] code;
    } plan_t;

    exp_t  q_exp[$];
    plan_t q_plan[$];
    int    exp_done = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Outcome of a task from the behavioural rules: engine reply after 'delay' RUN cycles (0 = never).
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] s, d, l,
                                   input int delay, input logic [7:0] code);
        exp_t e;
        e.op = op; e.src = s; e.dst = d; e.len = l;
        if (op > 2'd1)                       begin e.is_err = 1; e.code = 8'hFE; e.run_cycles = 0;     end
        else if (delay == 0 || delay > TMO)  begin e.is_err = 1; e.code = 8'hFF; e.run_cycles = TMO;   end
        else if (code == 8'h08)              begin e.is_err = 0; e.code = code;  e.run_cycles = delay; end
        else                                 begin e.is_err = 1; e.code = code;  e.run_cycles = delay; end
        return e;
    endfunction

    function automatic logic [1:0] route(input logic b, input logic s);
        return s ? {b, 1'b0} : {1'b0, b};
    endfunction

    initial begin : dma_driver
        forever begin
            @(posedge clk); #1;
            e_rd_rn = 2'($urandom()); e_wr_rn = 2'($urandom()); e_ff_rn = 2'($urandom());
            e_rd_addr = {$urandom(), $urandom()}; e_rd_len = {$urandom(), $urandom()};
            e_wr_addr = {$urandom(), $urandom()}; e_wr_len = {$urandom(), $urandom()};
            rd_done = 1'($urandom()); rd_err = 1'($urandom());
            wr_done = 1'($urandom()); wr_err = 1'($urandom());
        end
    end

    initial begin : engine_model
        logic [1:0] prev_rn;
        int         cnt [2];
        plan_t      cur [2];
        logic [7:0] low;
        prev_rn = 2'b00;
        eng_state = '0;
        forever begin
            @(negedge clk);
            for (int e = 0; e < 2; e++) begin
                if (eng_rn[e] && !prev_rn[e]) begin
                    if (q_plan.size() > 0) cur[e] = q_plan.pop_front();
                    else                   cur[e] = '{0, 8'h00};
                    cnt[e] = 0;
                end
                low = 8'($urandom_range(0, 7));
                if (eng_rn[e]) begin
                    cnt[e]++;
                    if (cur[e].delay != 0 && cnt[e] >= cur[e].delay) low = cur[e].code;
                end
                eng_state[e*32 +: 32] = {24'($urandom()), low};
            end
            prev_rn = eng_rn;
        end
    end

    initial begin : monitor
        logic [3:0]   prev, cur;
        int           iss_cnt, run_cnt;
        exp_t         e;
        logic [140:0] act, expv;
        logic         s;
        prev = 4'd0; iss_cnt = 0; run_cnt = 0;
        forever begin
            @(negedge clk);
            cur = st[3:0];
            act = {eng_rn, d_rd_rn, d_wr_rn, d_ff_rn, d_rd_addr, d_rd_len, d_wr_addr, d_wr_len,
                   o_rd_done, o_rd_err, o_wr_done, o_wr_err};
            expv = '0;
            if (cur == ST_RUN) begin
                if (q_exp.size() == 0) chk("run_without_task", cur, ST_IDLE);
                else begin
                    s = q_exp[0].op[0];
                    expv = {route(1'b1, s), e_rd_rn[s], e_wr_rn[s], e_ff_rn[s],
                            e_rd_addr[s*32 +: 32], e_rd_len[s*32 +: 32],
                            e_wr_addr[s*32 +: 32], e_wr_len[s*32 +: 32],
                            route(rd_done, s), route(rd_err, s), route(wr_done, s), route(wr_err, s)};
                end
            end
            chk("mux_outputs", act, expv);
            if (cur != prev) begin
                if (cur == ST_RUN && q_exp.size() > 0) begin
                    chk("issue_cycles", iss_cnt, ISS);
                    chk("engine_params", {eng_src, eng_dst, eng_len}, {q_exp[0].src, q_exp[0].dst, q_exp[0].len});
                    run_cnt = 0;
                end
                if (cur == ST_COMPLETE || cur == ST_ERROR) begin
                    if (q_exp.size() == 0) chk("unexpected_outcome", cur, ST_IDLE);
                    else begin
                        e = q_exp.pop_front();
                        chk("outcome", cur, e.is_err ? ST_ERROR : ST_COMPLETE);
                        if (e.is_err) chk("error_code", st[15:8], e.code);
                        chk("run_cycles", run_cnt, e.run_cycles);
                        if (!e.is_err) exp_done++;
                    end
                end
                if (prev == ST_COMPLETE) begin
                    chk("complete_to_idle", cur, ST_IDLE);
                    chk("done_count", st[31:16], 16'(exp_done));
                end
            end
            case (cur)
                ST_ISSUE: iss_cnt++;
                ST_RUN:   run_cnt++;
                ST_IDLE:  begin iss_cnt = 0; run_cnt = 0; end
                default:  ;
            endcase
            prev = cur;
        end
    end

    task automatic push_now(input logic [1:0] op, input logic [31:0] s, d, l,
                            input int delay, input logic [7:0] code);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = s; cmd_dst = d; cmd_len = l;
        q_exp.push_back(model(op, s, d, l, delay, code));
        if (op <= 2'd1) q_plan.push_back('{delay, code});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] s, d, l,
                        input int delay, input logic [7:0] code);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("push_ready_timeout", cmd_ready, 1'b1);
        else            push_now(op, s, d, l, delay, code);
    endtask

    task automatic wait_fsm(input logic [3:0] target, input int budget);
        int n = 0;
        @(negedge clk);
        while (st[3:0] != target && n < budget) begin @(negedge clk); n++; end
        if (st[3:0] != target) chk("wait_fsm", st[3:0], target);
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (!(st[3:0] == ST_IDLE && st[7:4] == 4'd0 && q_exp.size() == 0) && n < budget) begin
            @(negedge clk); n++;
        end
        chk({"quiet_", tag}, {st[7:0], 32'(q_exp.size())}, '0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        #1 chk("ready_during_clear", cmd_ready, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0;
        q_exp.delete(); q_plan.delete();
        @(negedge clk);
        chk("after_clear", st, {16'(exp_done), 16'h0000});
    endtask

    initial begin : global_limit
        #2_000_000;
        errors++;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        int lat;
        rst_n = 1'b0; clear = 1'b0; cmd_valid = 1'b0;
        cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", st, 32'h0);
        chk("reset_ready", cmd_ready, 1'b1);
        chk("reset_params", {eng_rn, eng_src, eng_dst, eng_len}, '0);

        // single colorconvert, with push-to-release latency
        @(negedge clk);
        push_now(2'd1, 32'h1000, 32'h2000, 32'd64, 20, 8'h08);
        lat = 1;
        while (!eng_rn[1] && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("push_to_release", lat, 2 + ISS);
        wait_quiet("single", 300);
        chk("single_done", st[31:16], 16'd1);

        // queue fill behind a long task
        push(2'd0, $urandom(), $urandom(), $urandom(), 60, 8'h08);
        wait_fsm(ST_RUN, 50);
        for (int i = 0; i < 4; i++)
            push(2'(i % 2 == 0 ? 1 : 0), $urandom(), $urandom(), $urandom(), 3 + int'($urandom_range(0, 12)), 8'h08);
        @(negedge clk);
        chk("ready_when_full", cmd_ready, 1'b0);
        chk("level_full", st[7:4], 4'(DEPTH));
        wait_quiet("fill", 1000);
        chk("fill_done", st[31:16], 16'd6);

        // engine error with two entries left behind
        push(2'd0, $urandom(), $urandom(), $urandom(), 10, 8'h0A);
        push(2'd1, $urandom(), $urandom(), $urandom(), 5, 8'h08);
        push(2'd0, $urandom(), $urandom(), $urandom(), 5, 8'h08);
        wait_fsm(ST_ERROR, 200);
        @(negedge clk);
        chk("error_hold", st[15:0], {8'h0A, 4'd2, 4'(ST_ERROR)});
        do_clear();

        // watchdog, then done exactly on the timeout cycle
        push(2'd1, $urandom(), $urandom(), $urandom(), 0, 8'h08);
        wait_fsm(ST_ERROR, 300);
        do_clear();
        push(2'd0, $urandom(), $urandom(), $urandom(), TMO, 8'h08);
        wait_quiet("timeout_edge", 300);

        // illegal opcode
        push(2'd3, $urandom(), $urandom(), $urandom(), 5, 8'h08);
        wait_fsm(ST_ERROR, 50);
        @(negedge clk);
        chk("illegal_hold", {eng_rn, st[15:0]}, {2'b00, 8'hFE, 4'd0, 4'(ST_ERROR)});
        do_clear();

        // random traffic
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            push(2'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(),
                 int'($urandom_range(1, 25)), 8'h08);
        end
        wait_quiet("random", 3000);

        // simultaneous push and pop at level 2
        push(2'd1, $urandom(), $urandom(), $urandom(), 30, 8'h08);
        wait_fsm(ST_RUN, 50);
        push(2'd0, $urandom(), $urandom(), $urandom(), 5, 8'h08);
        push(2'd1, $urandom(), $urandom(), $urandom(), 5, 8'h08);
        wait_fsm(ST_COMPLETE, 100);
        @(negedge clk);
        chk("level_before_pushpop", st[7:0], {4'd2, 4'(ST_IDLE)});
        push_now(2'd0, $urandom(), $urandom(), $urandom(), 4, 8'h08);
        @(negedge clk);
        chk("level_after_pushpop", st[7:0], {4'd2, 4'(ST_ISSUE)});
        wait_quiet("pushpop", 500);

        // asynchronous reset mid-RUN
        push(2'd0, $urandom(), $urandom(), $urandom(), 0, 8'h08);
        wait_fsm(ST_RUN, 50);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {st, eng_rn, eng_src, eng_dst, eng_len, d_rd_rn, d_wr_rn, d_ff_rn,
             d_rd_addr, d_rd_len, d_wr_addr, d_wr_len, o_rd_done, o_rd_err, o_wr_done, o_wr_err}, '0);
        q_exp.delete(); q_plan.delete();
        exp_done = 0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", {cmd_ready, st}, {1'b1, 32'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
